multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 15: maximum number of cycles spent waiting for mem_ready in a memory state.
REQ-002 SHALL have the following ports, one per line:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction bits [6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux select: 00 = ALU register, 01 = memory data, 10 = ALU direct.
- alu_src_a  out  2  ALU operand A select: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU operand B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  to the ALU-control decoder: 00 = add, 01 = subtract, 10 = decode from funct fields.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- mem_err  out  1  one-cycle pulse when a wait times out.
- state  out  4  current state encoding, for debug.

Function
REQ-003 SHALL implement an FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, BEQ=9, JAL=10.
REQ-004 Outputs SHALL be decoded combinationally from state, mem_ready and zero; any output not listed for a state SHALL be 0.
REQ-005 FETCH SHALL drive adr_src=0 and mem_read=1.
REQ-006 In FETCH with mem_ready=1, it SHALL also drive ir_write=1, pc_write=1, a=00, b=10, alu_op=00 and result_src=10, then go to DECODE; otherwise it SHALL hold.
REQ-007 DECODE SHALL drive a=01, b=01, alu_op=00.
REQ-008 DECODE next state by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- anything else -> FETCH with illegal=1
REQ-009 MEMADR SHALL drive a=10, b=01, alu_op=00; it goes to MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-010 MEMREAD SHALL drive adr_src=1 and mem_read=1; it goes to MEMWB on mem_ready=1, otherwise holds.
REQ-011 MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-012 MEMWRITE SHALL drive adr_src=1 and mem_write=1; it goes to FETCH on mem_ready=1, otherwise holds.
REQ-013 EXECR SHALL drive a=10, b=00, alu_op=10; EXECI SHALL drive a=10, b=01, alu_op=10; both go to ALUWB.
REQ-014 ALUWB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-015 BEQ SHALL drive a=10, b=00, alu_op=01, result_src=00 and pc_write=zero, then go to FETCH.
REQ-016 A wait counter SHALL increment each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0, and SHALL clear on every state change.
REQ-017 When the wait counter equals WAIT_TIMEOUT with mem_ready=0, the FSM SHALL:
- pulse mem_err for that cycle;
- suppress pc_write, ir_write, reg_write and mem_write in that cycle;
- go to FETCH, with the counter cleared.
REQ-018 mem_ready=1 arriving in the same cycle the counter reaches WAIT_TIMEOUT SHALL complete the access normally; no mem_err.
REQ-019 Every instruction SHALL end in FETCH. Latency including FETCH with zero wait states:
- lw 5 cycles
- sw 4
- R-type 4
- I-type 4
- beq 3

Reset
REQ-020 While rst_n=0, state SHALL be FETCH and the wait counter 0, asynchronously.
REQ-021 While rst_n=0, all outputs other than mem_read (1 in FETCH) and state (0) SHALL be 0.
REQ-022 Reset asserted mid-instruction SHALL abandon it with no further writes; after deassertion, fetch SHALL resume on the first clk edge.

Configuration
REQ-023 With MULTICYCLE_CTRL_JAL_EN defined:
- opcode 1101111 in DECODE SHALL go to JAL;
- JAL SHALL drive a=01, b=10, alu_op=00, result_src=00 and pc_write=1, then go to ALUWB.
REQ-024 Without MULTICYCLE_CTRL_JAL_EN, opcode 1101111 SHALL be illegal per REQ-008 and encoding 10 SHALL be unreachable.

Verification
REQ-025 lw (0000011), mem_ready always 1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4.
REQ-026 beq (1100011) with zero=1 -> pc_write=1 in BEQ with alu_op=01; with zero=0 -> pc_write=0 in BEQ.
REQ-027 sw with mem_ready low 3 cycles in MEMWRITE -> mem_write high 4 cycles; state 5->0 on the 4th; no mem_err.
REQ-028 FETCH with mem_ready held 0, WAIT_TIMEOUT=15 -> mem_err pulses on the 16th FETCH cycle; ir_write stays 0; next state FETCH.
REQ-029 opcode 1111111 in DECODE -> illegal=1 for 1 cycle and next state 0; opcode 1101111 -> illegal=1 without JAL_EN, state 10 then 7 with it.
REQ-030 rst_n pulsed low during MEMREAD -> state=0 immediately; reg_write never asserts for that lw.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM with memory wait timeout.
// Optional JAL support enabled by defining MULTICYCLE_CTRL_JAL_EN.
module multicycle_control #(
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int CW =
    (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef MULTICYCLE_CTRL_JAL_EN
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  state_e          state_q, state_d;
  state_e          dec_next;
  logic            dec_ok;
  logic [CW-1:0]   wait_q, wait_d;
  logic            waiting;
  logic            timeout;

  assign waiting = (state_q == S_FETCH)   ||
                   (state_q == S_MEMREAD) ||
                   (state_q == S_MEMWRITE);

  // A stalled access gives up once the counter has hit the limit.
  assign timeout = waiting && !mem_ready &&
                   (wait_q == CW'(WAIT_TIMEOUT));

  assign state = state_q;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Opcode decode used when leaving DECODE.
  always_comb begin
    dec_ok   = 1'b1;
    dec_next = S_FETCH;
    unique case (1'b1)
      (opcode == OP_LOAD),
      (opcode == OP_STORE): dec_next = S_MEMADR;
      (opcode == OP_RTYPE): dec_next = S_EXECR;
      (opcode == OP_ITYPE): dec_next = S_EXECI;
      (opcode == OP_BEQ):   dec_next = S_BEQ;
`ifdef MULTICYCLE_CTRL_JAL_EN
      (opcode == OP_JAL):   dec_next = S_JAL;
`endif
      default:              dec_ok   = 1'b0;
    endcase
  end

  // Next-state and wait counter update.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout)        state_d = S_FETCH;
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE:   state_d = dec_next;
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
      S_JAL:      state_d = S_ALUWB;
`endif
      default:    state_d = S_FETCH;
    endcase

    if (timeout || (state_d != state_q))
      wait_d = '0;
    else if (waiting && !mem_ready)
      wait_d = wait_q + 1'b1;
    else
      wait_d = wait_q;
  end

  // Control outputs from current state and status inputs.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    if (!rst_n) begin
      mem_read = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          mem_err  = timeout;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          illegal   = !dec_ok;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          adr_src  = 1'b1;
          mem_read = 1'b1;
          mem_err  = timeout;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = !timeout;
          mem_err   = timeout;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = zero;
        end
`ifdef MULTICYCLE_CTRL_JAL_EN
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios then random
// instruction streams checked against an instruction-path model.
module tb_multicycle_control;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_read, mem_write;
  logic       ir_write, reg_write, illegal, mem_err;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

  // model: current step, stall count, remaining steps of instruction
  int cur = 0;
  int wcnt = 0;
  int path[$];

  multicycle_control #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [6:0] op);
    bit ok;
    ok = (op == 7'b0000011) || (op == 7'b0100011) ||
         (op == 7'b0110011) || (op == 7'b0010011) ||
         (op == 7'b1100011);
`ifdef MULTICYCLE_CTRL_JAL_EN
    ok = ok || (op == 7'b1101111);
`endif
    return ok;
  endfunction

  // Steps an instruction walks through after DECODE.
  function automatic void load_path(input logic [6:0] op);
    path.delete();
    case (op)
      7'b0000011: path = '{2, 3, 4};
      7'b0100011: path = '{2, 5};
      7'b0110011: path = '{6, 7};
      7'b0010011: path = '{8, 7};
      7'b1100011: path = '{9};
      7'b1101111: path = '{10, 7};
      default:    path.delete();
    endcase
  endfunction

  function automatic bit stall_step(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic [19:0] expv();
    logic pcw, adr, mrd, mwr, irw, rgw, ill, me, to;
    logic [1:0] rs, a, b, op;
    pcw = 0; adr = 0; mrd = 0; mwr = 0; irw = 0; rgw = 0;
    ill = 0; me = 0; rs = 0; a = 0; b = 0; op = 0;
    if (!rst_n) return 20'h20000;
    to = stall_step(cur) && !mem_ready && (wcnt == TO);
    case (cur)
      0: begin
        mrd = 1; me = to;
        if (mem_ready) begin
          irw = 1; pcw = 1; b = 2'b10; rs = 2'b10;
        end
      end
      1: begin a = 2'b01; b = 2'b01; ill = !is_legal(opcode); end
      2: begin a = 2'b10; b = 2'b01; end
      3: begin adr = 1; mrd = 1; me = to; end
      4: begin rs = 2'b01; rgw = 1; end
      5: begin adr = 1; mwr = !to; me = to; end
      6: begin a = 2'b10; op = 2'b10; end
      7: rgw = 1;
      8: begin a = 2'b10; b = 2'b01; op = 2'b10; end
      9: begin a = 2'b10; op = 2'b01; pcw = zero; end
      10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, mrd, mwr, irw, rgw, rs, a, b, op,
            ill, me, 4'(cur)};
  endfunction

  task automatic check(input string tag);
    logic [19:0] o, e;
    o = {pc_write, adr_src, mem_read, mem_write, ir_write,
         reg_write, result_src, alu_src_a, alu_src_b, alu_op,
         illegal, mem_err, state};
    e = expv();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s t=%0t obs=%05h exp=%05h", tag, $time, o, e);
    end
  endtask

  function automatic void next_step();
    int n;
    n = (path.size() > 0) ? path.pop_front() : 0;
    if (n != cur) wcnt = 0;
    cur = n;
  endfunction

  // Advance the model across one clock edge.
  function automatic void adv(input logic mr);
    bit to;
    to = stall_step(cur) && !mr && (wcnt == TO);
    if (to) begin
      cur = 0; wcnt = 0; path.delete();
    end else if (stall_step(cur) && !mr) begin
      wcnt++;
    end else if (cur == 0) begin
      cur = 1; wcnt = 0;
    end else if (cur == 1) begin
      if (is_legal(opcode)) load_path(opcode);
      else path.delete();
      next_step();
    end else begin
      next_step();
    end
  endfunction

  function automatic void model_reset();
    cur = 0; wcnt = 0; path.delete();
  endfunction

  // Entered and left at posedge+1.
  task automatic cyc(input logic mr, input logic z, input string tag);
    mem_ready = mr;
    zero = z;
    @(negedge clk);
    check(tag);
    @(posedge clk);
    adv(mr);
    #1;
  endtask

  task automatic run_op(input logic [6:0] op, input int n,
                        input logic z, input string tag);
    opcode = op;
    for (int i = 0; i < n; i++) cyc(1'b1, z, tag);
  endtask

  logic [6:0] ops[7];
  logic       mr;

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1111111};

    #2 rst_n = 1'b0;
    #1 check("rst_async");
    @(negedge clk); check("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(7'b0000011, 5, 1'b0, "lw");
    run_op(7'b1100011, 3, 1'b1, "beq_z1");
    run_op(7'b1100011, 3, 1'b0, "beq_z0");
    run_op(7'b0110011, 4, 1'b0, "rtype");
    run_op(7'b0010011, 4, 1'b0, "itype");

    opcode = 7'b0100011;
    cyc(1'b1, 1'b0, "sw_f");
    cyc(1'b1, 1'b0, "sw_d");
    cyc(1'b1, 1'b0, "sw_a");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "sw_wait");
    cyc(1'b1, 1'b0, "sw_done");

    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, "fetch_to");
    cyc(1'b0, 1'b0, "fetch_after_to");

    run_op(7'b1111111, 2, 1'b0, "ill_ff");
    run_op(7'b1101111, 2, 1'b0, "jal_op");
`ifdef MULTICYCLE_CTRL_JAL_EN
    run_op(7'b1101111, 2, 1'b0, "jal_tail");
`endif

    opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "lw_edge");
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, "lw_edge_w");
    cyc(1'b1, 1'b0, "lw_edge_rdy");
    cyc(1'b1, 1'b0, "lw_edge_wb");

    opcode = 7'b0100011;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "sw_to");
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, "sw_to_w");

    while (cur != 0) cyc(1'b1, 1'b0, "drain");
    opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "lw_rst");
    cyc(1'b0, 1'b0, "lw_rst_w");
    rst_n = 1'b0;
    mem_ready = 1'b1;
    model_reset();
    #1 check("rst_mid");
    @(negedge clk); check("rst_mid_hold");
    @(posedge clk); #1;
    check("rst_mid_edge");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, "lw_after_rst");

    for (int i = 0; i < 2500; i++) begin
      if (cur == 0) begin
        if ($urandom_range(0, 7) == 0) opcode = 7'($urandom);
        else opcode = ops[$urandom_range(0, 6)];
      end
      if (((i / 250) % 2) == 1)
        mr = ($urandom_range(0, 19) == 0);
      else
        mr = ($urandom_range(0, 3) != 0);
      cyc(mr, 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
